// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Purpose  : Shared geometry, FSM states and line metadata for the data cache
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   localparam int NUM_LINES_DEF = 16;
   localparam int LINE_BITS_DEF = 256;
   localparam int ADDR_W_DEF    = 32;

   localparam int OFFSET_W   = 5;
   localparam int WORD_SEL_W = 3;
   localparam int INDEX_W    = $clog2(NUM_LINES_DEF);
   localparam int TAG_W      = ADDR_W_DEF - INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      REFILL    = 2'd3
   } state_t;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } line_meta_t;

   function automatic logic [31:0] select_word(input logic [LINE_BITS_DEF-1:0] line,
                                               input logic [WORD_SEL_W-1:0]    sel);
      return line[{sel, 5'd0} +: 32];
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_line_store
//  Purpose  : Tag/valid/dirty and line data arrays, async read, sync write
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = NUM_LINES_DEF,
   parameter int LINE_BITS = LINE_BITS_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [INDEX_W-1:0]    i_index,
   input  logic                  i_line_we,
   input  logic [TAG_W-1:0]      i_tag,
   input  logic [LINE_BITS-1:0]  i_line,
   input  logic                  i_word_we,
   input  logic [WORD_SEL_W-1:0] i_word_sel,
   input  logic [31:0]           i_word,
   output line_meta_t            o_meta,
   output logic [LINE_BITS-1:0]  o_line
);

   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [LINE_BITS-1:0] r_data [NUM_LINES];

   // Only the status bits are reset; tags and data are don't-care while invalid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_line_we) begin
         r_valid[i_index] <= 1'b1;
         r_dirty[i_index] <= 1'b0;
      end else if (i_word_we) begin
         r_dirty[i_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (i_line_we) begin
         r_tag[i_index]  <= i_tag;
         r_data[i_index] <= i_line;
      end else if (i_word_we) begin
         r_data[i_index][{i_word_sel, 5'd0} +: 32] <= i_word;
      end
   end

   assign o_meta.valid = r_valid[i_index];
   assign o_meta.dirty = r_dirty[i_index];
   assign o_meta.tag   = r_tag[i_index];
   assign o_line       = r_data[i_index];

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_controller
//  Purpose  : Direct-mapped write-back/write-allocate data cache for the MEM stage
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = NUM_LINES_DEF,
   parameter int LINE_BITS = LINE_BITS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [31:0]          data_i,
   output logic [31:0]          data_o,
   output logic                 stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);

   state_t                r_state;
   state_t                w_next;
   line_meta_t            w_meta;
   logic [LINE_BITS-1:0]  w_line;
   logic [TAG_W-1:0]      w_tag;
   logic [INDEX_W-1:0]    w_index;
   logic [WORD_SEL_W-1:0] w_word;
   logic                  w_hit;
   logic                  w_line_we;
   logic                  w_word_we;
   logic                  w_unused_addr;

   assign w_tag         = addr_i[ADDR_W-1 -: TAG_W];
   assign w_index       = addr_i[OFFSET_W +: INDEX_W];
   assign w_word        = addr_i[2 +: WORD_SEL_W];
   assign w_unused_addr = ^addr_i[1:0];
   assign w_hit         = w_meta.valid && (w_meta.tag == w_tag);

   dcache_line_store #(
      .NUM_LINES (NUM_LINES),
      .LINE_BITS (LINE_BITS)
   ) u_store (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_index    (w_index),
      .i_line_we  (w_line_we),
      .i_tag      (w_tag),
      .i_line     (mem_data_i),
      .i_word_we  (w_word_we),
      .i_word_sel (w_word),
      .i_word     (data_i),
      .o_meta     (w_meta),
      .o_line     (w_line)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // The request is held stable during a miss, so index/tag keep addressing the victim line.
   always_comb begin
      w_next       = r_state;
      stall_o      = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      data_o       = '0;
      w_line_we    = 1'b0;
      w_word_we    = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_i && !rst_i) begin
               if (w_hit) begin
                  if (we_i) w_word_we = 1'b1;
                  else      data_o    = select_word(w_line, w_word);
               end else begin
                  stall_o = 1'b1;
                  w_next  = (w_meta.valid && w_meta.dirty) ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            stall_o      = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {w_meta.tag, w_index, {OFFSET_W{1'b0}}};
            mem_data_o   = w_line;
            if (mem_ack_i) w_next = ALLOCATE;
         end
         ALLOCATE: begin
            stall_o      = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = {w_tag, w_index, {OFFSET_W{1'b0}}};
            if (mem_ack_i) begin
               w_line_we = 1'b1;
               w_next    = REFILL;
            end
         end
         REFILL: begin
            stall_o = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule
`default_nettype wire
